hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit.sv | 79 +++++++
 tb/tb_hazard_ctrl_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: operand forwarding, load-use/branch hazard control, cache-miss stall FSM and perf counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_reg_we_mem,
  input  logic                  i_reg_we_wb,
  input  logic                  i_pc_src_exec,
  input  logic                  i_load_instr_exec,
  input  logic                  i_instr_miss,
  input  logic                  i_data_miss,
  input  logic                  i_cnt_clear,
  output logic                  o_stall_fetch,
  output logic                  o_stall_dec,
  output logic                  o_flush_dec,
  output logic                  o_flush_exec,
  output logic [1:0]            o_forward_rs1,
  output logic [1:0]            o_forward_rs2,
  output logic                  o_stall_core,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles,
  output logic [CNT_WIDTH-1:0]  o_flush_count,
  output logic [CNT_WIDTH-1:0]  o_load_use_count
);
  typedef enum logic [1:0] {RUN, ISTALL, DSTALL, DRAIN} state_t;
  state_t r_state, w_next;
  logic [CNT_WIDTH-1:0] r_stall_cycles, r_flush_count, r_load_use_count;
  logic w_load_use, w_stall, w_lu_cnt, w_active;
  function automatic logic [1:0] fwd(input logic [REG_ADDR_W-1:0] rs);
    return (i_reg_we_mem && i_rd_addr_mem != '0 && i_rd_addr_mem == rs) ? 2'b10 :
           (i_reg_we_wb  && i_rd_addr_wb  != '0 && i_rd_addr_wb  == rs) ? 2'b01 : 2'b00;
  endfunction
  assign w_active = !i_arst;
  assign o_forward_rs1 = w_active ? fwd(i_rs1_addr_exec) : 2'b00;
  assign o_forward_rs2 = w_active ? fwd(i_rs2_addr_exec) : 2'b00;
  assign w_load_use = i_load_instr_exec && i_rd_addr_exec != '0 &&
                      (i_rd_addr_exec == i_rs1_addr_dec || i_rd_addr_exec == i_rs2_addr_dec);
  // The DSTALL cycle in which the D-miss has dropped is the single drain stall; DRAIN only steers the exit.
  assign w_stall = w_active && (i_instr_miss || i_data_miss || r_state == ISTALL || r_state == DSTALL);
  assign w_lu_cnt = w_active && !w_stall && w_load_use && !i_pc_src_exec;
  assign o_stall_core  = w_stall;
  assign o_stall_fetch = w_stall || w_lu_cnt;
  assign o_stall_dec   = w_stall || w_lu_cnt;
  assign o_flush_dec   = w_active && !w_stall && i_pc_src_exec;
  assign o_flush_exec  = w_active && !w_stall && (i_pc_src_exec || w_load_use);
  assign o_stall_cycles   = r_stall_cycles;
  assign o_flush_count    = r_flush_count;
  assign o_load_use_count = r_load_use_count;
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN, ISTALL: w_next = i_data_miss ? DSTALL : i_instr_miss ? ISTALL : RUN;
      DSTALL:      w_next = i_data_miss ? DSTALL : DRAIN;
      DRAIN:       w_next = i_instr_miss ? ISTALL : RUN;
      default:     w_next = RUN;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_state          <= RUN;
      r_stall_cycles   <= '0;
      r_flush_count    <= '0;
      r_load_use_count <= '0;
    end else begin
      r_state          <= w_next;
      r_stall_cycles   <= i_cnt_clear ? '0 : r_stall_cycles + CNT_WIDTH'(w_stall);
      r_flush_count    <= i_cnt_clear ? '0 : r_flush_count + CNT_WIDTH'(o_flush_dec);
      r_load_use_count <= i_cnt_clear ? '0 : r_load_use_count + CNT_WIDTH'(w_lu_cnt);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: scoreboard bench; a behavioural model queues expected outputs, a negedge monitor compares.
module tb_hazard_ctrl_unit;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMOD = 1 << CW;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  logic arst, clr, pc, ld, im, dm, wem, wew;
  logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic sf, sd, fd, fe, sc;
  logic [1:0] f1, f2;
  logic [CW-1:0] c_st, c_fl, c_lu;
  hazard_ctrl_unit #(.REG_ADDR_W(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_arst(arst),
    .i_rs1_addr_dec(rs1d), .i_rs2_addr_dec(rs2d),
    .i_rs1_addr_exec(rs1e), .i_rs2_addr_exec(rs2e), .i_rd_addr_exec(rde),
    .i_rd_addr_mem(rdm), .i_rd_addr_wb(rdw),
    .i_reg_we_mem(wem), .i_reg_we_wb(wew),
    .i_pc_src_exec(pc), .i_load_instr_exec(ld),
    .i_instr_miss(im), .i_data_miss(dm), .i_cnt_clear(clr),
    .o_stall_fetch(sf), .o_stall_dec(sd), .o_flush_dec(fd), .o_flush_exec(fe),
    .o_forward_rs1(f1), .o_forward_rs2(f2), .o_stall_core(sc),
    .o_stall_cycles(c_st), .o_flush_count(c_fl), .o_load_use_count(c_lu)
  );
  typedef struct {
    logic [1:0] f1, f2;
    logic sf, sd, fd, fe, sc;
    int c_st, c_fl, c_lu;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int total = 0, bad = 0;
  bit in_d = 0, in_i = 0, draining = 0;
  int m_st = 0, m_fl = 0, m_lu = 0;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endfunction
  function automatic logic [1:0] mfwd(input logic [AW-1:0] rs);
    if (arst) return 2'b00;
    if (wem && rdm != 0 && rdm == rs) return 2'b10;
    if (wew && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction
  task automatic idle();
    {arst, clr, pc, ld, im, dm, wem, wew} = '0;
    {rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw} = '0;
  endtask
  // Inputs are already applied; queue the expected response, then advance the model past the edge.
  task automatic cyc();
    exp_t e;
    bit lu, st, lu_inc;
    lu = ld && rde != 0 && (rde == rs1d || rde == rs2d);
    st = !arst && (im || dm || in_i || in_d);
    lu_inc = !arst && !st && lu && !pc;
    e.f1 = mfwd(rs1e);
    e.f2 = mfwd(rs2e);
    e.sc = st;
    e.sf = st || lu_inc;
    e.sd = st || lu_inc;
    e.fd = !arst && !st && pc;
    e.fe = !arst && !st && (pc || lu);
    e.c_st = m_st;
    e.c_fl = m_fl;
    e.c_lu = m_lu;
    q.push_back(e);
    if (arst || clr) begin
      m_st = 0; m_fl = 0; m_lu = 0;
    end else begin
      m_st = (m_st + int'(st)) % CMOD;
      m_fl = (m_fl + int'(e.fd)) % CMOD;
      m_lu = (m_lu + int'(lu_inc)) % CMOD;
    end
    if (arst) begin
      in_d = 0; in_i = 0; draining = 0;
    end else if (in_d) begin
      in_d = dm; draining = !dm;
    end else if (draining) begin
      draining = 0; in_i = im;
    end else if (dm) begin
      in_d = 1; in_i = 0;
    end else begin
      in_i = im;
    end
    @(posedge i_clk);
    #1;
  endtask
  always @(negedge i_clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk("forward_rs1", 32'(f1), 32'(me.f1));
      chk("forward_rs2", 32'(f2), 32'(me.f2));
      chk("stall_fetch", 32'(sf), 32'(me.sf));
      chk("stall_dec", 32'(sd), 32'(me.sd));
      chk("flush_dec", 32'(fd), 32'(me.fd));
      chk("flush_exec", 32'(fe), 32'(me.fe));
      chk("stall_core", 32'(sc), 32'(me.sc));
      chk("stall_cycles", 32'(c_st), me.c_st);
      chk("flush_count", 32'(c_fl), me.c_fl);
      chk("load_use_count", 32'(c_lu), me.c_lu);
    end
  end
  initial begin
    idle();
    arst = 1;
    @(posedge i_clk);
    #1;
    cyc();
    arst = 0;
    wem = 1; wew = 1; rdm = 5; rdw = 5; rs1e = 5; rs2e = 5;
    cyc();
    rdm = 0; rdw = 0; rs1e = 0; rs2e = 0;
    cyc();
    idle(); rdw = 3; wew = 1; rs2e = 3;
    cyc();
    idle(); ld = 1; rde = 7; rs2d = 7;
    cyc();
    idle();
    cyc();
    ld = 1; rde = 7; rs2d = 7; pc = 1;
    cyc();
    idle(); clr = 1;
    cyc();
    clr = 0; dm = 1;
    repeat (4) cyc();
    dm = 0;
    repeat (3) cyc();
    im = 1;
    repeat (2) cyc();
    dm = 1;
    repeat (2) cyc();
    im = 0; dm = 0; pc = 1;
    repeat (4) cyc();
    idle(); dm = 1;
    repeat (2) cyc();
    arst = 1;
    cyc();
    idle();
    repeat (2) cyc();
    clr = 1;
    cyc();
    clr = 0; pc = 1;
    repeat (CMOD - 1) cyc();
    cyc();
    cyc();
    clr = 1;
    cyc();
    idle();
    cyc();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) im = ~im;
      if ($urandom_range(0, 9) == 0) dm = ~dm;
      rs1d = AW'($urandom_range(0, 3));
      rs2d = AW'($urandom_range(0, 3));
      rs1e = AW'($urandom_range(0, 3));
      rs2e = AW'($urandom_range(0, 3));
      rde  = AW'($urandom_range(0, 3));
      rdm  = AW'($urandom_range(0, 3));
      rdw  = AW'($urandom_range(0, 3));
      wem  = 1'($urandom_range(0, 1));
      wew  = 1'($urandom_range(0, 1));
      pc   = ($urandom_range(0, 3) == 0);
      ld   = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      arst = ($urandom_range(0, 127) == 0);
      cyc();
    end
    idle();
    repeat (2) cyc();
    repeat (2) @(negedge i_clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
